rv_serial_divider: RTL and testbench

//  Iterative radix-2 restoring integer divider for the execute-stage ALU. Inverse companion of the

---
 rtl/rv_serial_divider.sv | 159 +++++++++++++++
 tb/tb_rv_serial_divider.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv_serial_divider.sv
// Radix-2 restoring divider producing RISC-V DIV/DIVU/REM/REMU results, one quotient bit per cycle.
// Optional build macro RV_DIV_EARLY_OUT_EN finishes |dividend| < |divisor| requests in one cycle.
module rv_serial_divider #(
    parameter int WIDTH  = 32,
    parameter int TAGW   = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAGW-1:0]  tag_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [TAGW-1:0]  tag_out,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   prem_q, prem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [TAGW-1:0]  tag_q, tag_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             is_zero, is_ovf, is_early;
    logic [WIDTH:0]   rem_shift, rem_diff, rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] quo_next;

    always_comb begin
        dvd_neg = (SIGNED != 0) && dividend[WIDTH-1];
        dvs_neg = (SIGNED != 0) && divisor[WIDTH-1];
        dvd_mag = dvd_neg ? -dividend : dividend;
        dvs_mag = dvs_neg ? -divisor : divisor;
        is_zero = (divisor == '0);
        is_ovf  = (SIGNED != 0) && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
`ifdef RV_DIV_EARLY_OUT_EN
        is_early = !is_zero && (dvd_mag < dvs_mag);
`else
        is_early = 1'b0;
`endif
    end

    // The partial remainder stays below the divisor, so its top bit is always zero before the shift.
    always_comb begin
        rem_shift = {prem_q[WIDTH-1:0], dvd_q[WIDTH-1]} | {prem_q[WIDTH], {WIDTH{1'b0}}};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        q_bit     = ~rem_diff[WIDTH];
        rem_next  = q_bit ? rem_diff : rem_shift;
        quo_next  = {dvd_q[WIDTH-2:0], q_bit};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prem_d      = prem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        tag_d       = tag_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (valid_in) begin
                        tag_d = tag_in;
                        if (is_zero) begin
                            quotient_d  = '1;
                            remainder_d = dividend;
                            state_d     = S_DONE;
                        end else if (is_ovf) begin
                            quotient_d  = dividend;
                            remainder_d = '0;
                            state_d     = S_DONE;
                        end else if (is_early) begin
                            quotient_d  = '0;
                            remainder_d = dividend;
                            state_d     = S_DONE;
                        end else begin
                            dvd_d     = dvd_mag;
                            dvs_d     = dvs_mag;
                            prem_d    = '0;
                            cnt_d     = CW'(WIDTH - 1);
                            neg_quo_d = dvd_neg ^ dvs_neg;
                            neg_rem_d = dvd_neg;
                            state_d   = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    prem_d = rem_next;
                    dvd_d  = quo_next;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        quotient_d  = neg_quo_q ? -quo_next : quo_next;
                        remainder_d = neg_rem_q ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
                        state_d     = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ready_out) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            prem_q      <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            tag_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prem_q      <= prem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            tag_q       <= tag_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
        end
    end

    assign ready_in  = enable && (state_q == S_IDLE);
    assign valid_out = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_rv_serial_divider.sv
// Bench for rv_serial_divider: unsigned and signed instances, vector table, random ops vs arithmetic model.
module tb_rv_serial_divider;

`ifdef RV_DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif
    localparam int EL = EARLY ? 1 : 33;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       enable_v = 2'b11;
    logic [1:0]       valid_in_v = 2'b00;
    logic [1:0]       ready_in_v;
    logic [1:0][31:0] dividend_v = '0;
    logic [1:0][31:0] divisor_v = '0;
    logic [1:0][7:0]  tag_in_v = '0;
    logic [1:0]       valid_out_v;
    logic [1:0]       ready_out_v = 2'b00;
    logic [1:0][31:0] quotient_v;
    logic [1:0][31:0] remainder_v;
    logic [1:0][7:0]  tag_out_v;
    logic [1:0]       busy_v;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_serial_divider #(.WIDTH(32), .TAGW(8), .SIGNED(0)) u_divu (
        .clk(clk), .reset(reset), .enable(enable_v[0]), .valid_in(valid_in_v[0]),
        .ready_in(ready_in_v[0]), .dividend(dividend_v[0]), .divisor(divisor_v[0]),
        .tag_in(tag_in_v[0]), .valid_out(valid_out_v[0]), .ready_out(ready_out_v[0]),
        .quotient(quotient_v[0]), .remainder(remainder_v[0]), .tag_out(tag_out_v[0]),
        .busy(busy_v[0])
    );

    rv_serial_divider #(.WIDTH(32), .TAGW(8), .SIGNED(1)) u_divs (
        .clk(clk), .reset(reset), .enable(enable_v[1]), .valid_in(valid_in_v[1]),
        .ready_in(ready_in_v[1]), .dividend(dividend_v[1]), .divisor(divisor_v[1]),
        .tag_in(tag_in_v[1]), .valid_out(valid_out_v[1]), .ready_out(ready_out_v[1]),
        .quotient(quotient_v[1]), .remainder(remainder_v[1]), .tag_out(tag_out_v[1]),
        .busy(busy_v[1])
    );

    typedef struct {
        int          s;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  tag;
        logic [31:0] q;
        logic [31:0] r;
        int          lat;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic with the ISA corner cases layered on top.
    function automatic void ref_div(input int s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, sq, sr, ma, mb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; lat = 1;
        end else if (s == 1) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            sq = sa / sb; sr = sa % sb;
            q = sq[31:0]; r = sr[31:0];
            ma = (sa < 0) ? -sa : sa; mb = (sb < 0) ? -sb : sb;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) lat = 1;
            else lat = (EARLY && ma < mb) ? 1 : 33;
        end else begin
            q = a / b; r = a % b;
            lat = (EARLY && a < b) ? 1 : 33;
        end
    endfunction

    task automatic do_txn(input int s, input logic [31:0] a, input logic [31:0] b, input logic [7:0] tg,
                          input int stall_at, input int stall_len, input bit hand,
                          output logic [31:0] q, output logic [31:0] r, output logic [7:0] to,
                          output int lat);
        int n = 0;
        while (!ready_in_v[s] && n < 100) begin
            @(posedge clk); #1; n++;
        end
        dividend_v[s] = a; divisor_v[s] = b; tag_in_v[s] = tg; valid_in_v[s] = 1'b1;
        @(posedge clk); #1;
        valid_in_v[s] = 1'b0;
        dividend_v[s] = $urandom; divisor_v[s] = $urandom; tag_in_v[s] = 8'($urandom);
        lat = 1;
        while (!valid_out_v[s] && lat < 300) begin
            enable_v[s] = !(stall_at > 0 && lat >= stall_at && lat < stall_at + stall_len);
            @(posedge clk); #1; lat++;
        end
        enable_v[s] = 1'b1;
        q = quotient_v[s]; r = remainder_v[s]; to = tag_out_v[s];
        $display("txn s=%0d a=%h b=%h tag=%h -> q=%h r=%h tag=%h lat=%0d", s, a, b, tg, q, r, to, lat);
        if (hand) begin
            ready_out_v[s] = 1'b1;
            @(posedge clk); #1;
            ready_out_v[s] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q, r, a, b, eq, er;
        logic [7:0]  t, tg;
        int          lat, elat, s, mode;

        vt[0]  = '{0, 32'd100,        32'd7,          8'h5A, 32'd14,         32'd2,          33};
        vt[1]  = '{1, 32'hFFFF_FFF9,  32'd2,          8'h01, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33};
        vt[2]  = '{1, 32'd7,          32'hFFFF_FFFE,  8'h02, 32'hFFFF_FFFD,  32'd1,          33};
        vt[3]  = '{0, 32'd5,          32'd0,          8'h03, 32'hFFFF_FFFF,  32'd5,          1};
        vt[4]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  8'h04, 32'h8000_0000,  32'd0,          1};
        vt[5]  = '{0, 32'd3,          32'd10,         8'h05, 32'd0,          32'd3,          EL};
        vt[6]  = '{1, 32'hFFFF_FFFB,  32'd0,          8'h06, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1};
        vt[7]  = '{1, 32'hFFFF_FFFD,  32'd10,         8'h07, 32'd0,          32'hFFFF_FFFD,  EL};
        vt[8]  = '{0, 32'hFFFF_FFFF,  32'd1,          8'h08, 32'hFFFF_FFFF,  32'd0,          33};
        vt[9]  = '{1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  8'h09, 32'd14,         32'hFFFF_FFFE,  33};
        vt[10] = '{0, 32'd0,          32'd7,          8'h0A, 32'd0,          32'd0,          EL};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_ready_in", 32'(ready_in_v[i]), 32'd1);
            chk("rst_valid_out", 32'(valid_out_v[i]), 32'd0);
            chk("rst_busy", 32'(busy_v[i]), 32'd0);
            chk("rst_quotient", quotient_v[i], 32'd0);
            chk("rst_remainder", remainder_v[i], 32'd0);
            chk("rst_tag_out", 32'(tag_out_v[i]), 32'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_txn(vt[i].s, vt[i].a, vt[i].b, vt[i].tag, 0, 0, 1'b1, q, r, t, lat);
            chk("vec_quotient", q, vt[i].q);
            chk("vec_remainder", r, vt[i].r);
            chk("vec_tag", 32'(t), 32'(vt[i].tag));
            chk("vec_latency", 32'(lat), 32'(vt[i].lat));
        end

        // Backpressure: result held for 10 cycles, then a single handoff.
        do_txn(0, 32'd100, 32'd7, 8'h33, 0, 0, 1'b0, q, r, t, lat);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk("bp_valid_out", 32'(valid_out_v[0]), 32'd1);
            chk("bp_ready_in", 32'(ready_in_v[0]), 32'd0);
            chk("bp_quotient", quotient_v[0], 32'd14);
            chk("bp_remainder", remainder_v[0], 32'd2);
        end
        ready_out_v[0] = 1'b1;
        @(posedge clk); #1;
        ready_out_v[0] = 1'b0;
        chk("bp_release_valid", 32'(valid_out_v[0]), 32'd0);
        chk("bp_release_busy", 32'(busy_v[0]), 32'd0);
        chk("bp_release_ready_in", 32'(ready_in_v[0]), 32'd1);
        chk("bp_hold_quotient", quotient_v[0], 32'd14);

        // Handoff must be ignored while the divider is stalled.
        do_txn(0, 32'd50, 32'd5, 8'h44, 0, 0, 1'b0, q, r, t, lat);
        enable_v[0] = 1'b0; ready_out_v[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("stall_done_valid", 32'(valid_out_v[0]), 32'd1);
        chk("stall_done_ready_in", 32'(ready_in_v[0]), 32'd0);
        enable_v[0] = 1'b1;
        @(posedge clk); #1;
        ready_out_v[0] = 1'b0;
        chk("stall_done_release", 32'(valid_out_v[0]), 32'd0);
        chk("stall_done_quotient", quotient_v[0], 32'd10);

        // Five stalled cycles mid-BUSY stretch latency by exactly five.
        do_txn(0, 32'd1000, 32'd9, 8'h55, 10, 5, 1'b1, q, r, t, lat);
        chk("stall_busy_latency", 32'(lat), 32'd38);
        chk("stall_busy_quotient", q, 32'd111);
        chk("stall_busy_remainder", r, 32'd1);

        // Reset during BUSY at cycle 12 drops the in-flight request.
        dividend_v[0] = 32'd1000; divisor_v[0] = 32'd3; tag_in_v[0] = 8'h66; valid_in_v[0] = 1'b1;
        @(posedge clk); #1;
        valid_in_v[0] = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        chk("pre_reset_busy", 32'(busy_v[0]), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_valid_out", 32'(valid_out_v[0]), 32'd0);
        chk("mid_reset_busy", 32'(busy_v[0]), 32'd0);
        chk("mid_reset_ready_in", 32'(ready_in_v[0]), 32'd1);
        chk("mid_reset_quotient", quotient_v[0], 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        do_txn(0, 32'd9, 32'd3, 8'h77, 0, 0, 1'b1, q, r, t, lat);
        chk("post_reset_quotient", q, 32'd3);
        chk("post_reset_remainder", r, 32'd0);
        chk("post_reset_latency", 32'(lat), 32'd33);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 60; i++) begin
            s = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case (mode)
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = a >> $urandom_range(8, 31);
                4: b = b >> $urandom_range(8, 31);
                default: ;
            endcase
            tg = 8'($urandom);
            ref_div(s, a, b, eq, er, elat);
            do_txn(s, a, b, tg, 0, 0, 1'b1, q, r, t, lat);
            chk("rnd_quotient", q, eq);
            chk("rnd_remainder", r, er);
            chk("rnd_tag", 32'(t), 32'(tg));
            chk("rnd_latency", 32'(lat), 32'(elat));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
